// File: rtl/wb_uart_stream_bridge.sv
// ============================================================================
// wb_uart_stream_bridge: Wishbone master turning wb_uart FIFOs into byte streams
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_uart_stream_bridge #(
  parameter int DATA_BITS        = 8,
  parameter int TX_FIFO_CAPACITY = 8,
  parameter int ACK_TIMEOUT      = 15,
  parameter int POLL_GAP         = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic [31:0]          wb_addr_out,
  output logic [31:0]          wb_data_out,
  input  logic [31:0]          wb_data_in,
  output logic                 wb_write_enable_out,
  output logic                 wb_strobe_out,
  input  logic                 wb_acknowledge_in,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_bus_error,
  output logic                 o_busy
);

  localparam int c_TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int c_GAP_W = $clog2(POLL_GAP + 2);

  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(POLL_GAP);
  localparam logic [7:0]         c_TX_CAP   = 8'(TX_FIFO_CAPACITY);

  localparam logic [31:0] c_ADDR_RX_FILL = 32'h0000_0001;
  localparam logic [31:0] c_ADDR_TX_FILL = 32'h0000_0002;
  localparam logic [31:0] c_ADDR_RX_DATA = 32'h0000_0011;
  localparam logic [31:0] c_ADDR_TX_DATA = 32'h0000_0012;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_POLL_RX = 3'd1;
  localparam logic [2:0] c_POP_RX  = 3'd2;
  localparam logic [2:0] c_POLL_TX = 3'd3;
  localparam logic [2:0] c_PUSH_TX = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic                 r_issue;
  logic [c_TMR_W-1:0]   r_tmr;
  logic [31:0]          r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [7:0]           r_rx_credit;
  logic [7:0]           r_tx_credit;
  logic [c_GAP_W-1:0]   r_rx_gap;
  logic [c_GAP_W-1:0]   r_tx_gap;
  logic                 r_rr_tx;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_bus_error;

  logic       w_wait;
  logic       w_ack;
  logic       w_timeout;
  logic       w_need_rx_poll;
  logic       w_need_tx_poll;
  logic [7:0] w_fill;
  logic [7:0] w_tx_free;
  logic       w_unused_data;

  // The strobe cycle never samples the acknowledge; only the wait cycles do.
  assign w_wait    = (r_state != c_IDLE) && !r_issue;
  assign w_ack     = w_wait && wb_acknowledge_in;
  assign w_timeout = w_wait && !wb_acknowledge_in && (r_tmr == c_TMR_LAST);

  assign w_need_rx_poll = !r_rx_valid && (r_rx_credit == 8'd0) && (r_rx_gap == '0);
  assign w_need_tx_poll = i_tx_valid && (r_tx_credit == 8'd0) && (r_tx_gap == '0);

  assign w_fill        = wb_data_in[7:0];
  assign w_tx_free     = (w_fill > c_TX_CAP) ? 8'd0 : (c_TX_CAP - w_fill);
  assign w_unused_data = ^wb_data_in[31:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
      r_issue <= 1'b0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_issue <= (r_state == c_IDLE) && (w_next_state != c_IDLE);
      if (r_issue) begin
        r_tmr <= '0;
      end else if (w_wait) begin
        r_tmr <= r_tmr + c_TMR_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if ((r_rx_credit != 8'd0) && !r_rx_valid) begin
          w_next_state = c_POP_RX;
        end else if (i_tx_valid && (r_tx_credit != 8'd0)) begin
          w_next_state = c_PUSH_TX;
        end else if (w_need_rx_poll && w_need_tx_poll) begin
          w_next_state = r_rr_tx ? c_POLL_TX : c_POLL_RX;
        end else if (w_need_rx_poll) begin
          w_next_state = c_POLL_RX;
        end else if (w_need_tx_poll) begin
          w_next_state = c_POLL_TX;
        end
      end
      default: begin
        if (w_ack || w_timeout) begin
          w_next_state = c_IDLE;
        end
      end
    endcase
  end

  // The TX byte is driven straight from the stream in the strobe cycle, then held from r_wdata.
  always_comb begin
    wb_strobe_out       = r_issue;
    wb_write_enable_out = (r_state == c_PUSH_TX);
    wb_data_out         = 32'd0;
    o_tx_ready          = 1'b0;
    if (r_state == c_PUSH_TX) begin
      if (r_issue) begin
        wb_data_out = 32'(i_tx_data);
        o_tx_ready  = 1'b1;
      end else begin
        wb_data_out = 32'(r_wdata);
      end
    end
    o_busy = (r_state != c_IDLE);
  end

  assign wb_addr_out = r_addr;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_bus_error = r_bus_error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= 32'd0;
      r_wdata     <= '0;
      r_rx_credit <= 8'd0;
      r_tx_credit <= 8'd0;
      r_rx_gap    <= '0;
      r_tx_gap    <= '0;
      r_rr_tx     <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) && (w_next_state != c_IDLE)) begin
        case (w_next_state)
          c_POLL_RX: r_addr <= c_ADDR_RX_FILL;
          c_POP_RX:  r_addr <= c_ADDR_RX_DATA;
          c_POLL_TX: r_addr <= c_ADDR_TX_FILL;
          default:   r_addr <= c_ADDR_TX_DATA;
        endcase
        if (w_next_state == c_POLL_RX) begin
          r_rr_tx <= 1'b1;
        end else if (w_next_state == c_POLL_TX) begin
          r_rr_tx <= 1'b0;
        end
      end

      if ((r_state == c_PUSH_TX) && r_issue) begin
        r_wdata <= i_tx_data;
      end

      r_rx_gap <= (r_rx_gap != '0) ? (r_rx_gap - c_GAP_W'(1)) : '0;
      r_tx_gap <= (r_tx_gap != '0) ? (r_tx_gap - c_GAP_W'(1)) : '0;

      if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_ack) begin
        case (r_state)
          c_POLL_RX: begin
            r_rx_credit <= w_fill;
            if (w_fill == 8'd0) begin
              r_rx_gap <= c_GAP_LOAD;
            end
          end
          c_POP_RX: begin
            r_rx_data  <= wb_data_in[DATA_BITS-1:0];
            r_rx_valid <= 1'b1;
            if (r_rx_credit != 8'd0) begin
              r_rx_credit <= r_rx_credit - 8'd1;
            end
          end
          c_POLL_TX: begin
            r_tx_credit <= w_tx_free;
            if (w_tx_free == 8'd0) begin
              r_tx_gap <= c_GAP_LOAD;
            end
          end
          default: begin
            if (r_tx_credit != 8'd0) begin
              r_tx_credit <= r_tx_credit - 8'd1;
            end
          end
        endcase
      end

      // An abandoned transaction leaves the slave state unknown, so credits must be re-polled.
      if (w_timeout) begin
        r_bus_error <= 1'b1;
        r_rx_credit <= 8'd0;
        r_tx_credit <= 8'd0;
      end
    end
  end

endmodule

`default_nettype wire
